// File: rtl/decode_stage_reg_if.sv
// Handshake bundle for the decode stage: IF/ID input side and ID/EX output side.
// Ports: in_valid/in_ready/in_instr/in_pc (upstream), out_valid/out_ready plus the decoded control bundle (downstream).
// master = the environment (upstream and downstream), slave = the decode stage.
interface decode_stage_reg_if #(
    parameter int ADDR_W    = 32,
    parameter int ALUCODE_W = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_instr;
    logic [ADDR_W-1:0]    in_pc;

    logic                 out_valid;
    logic                 out_ready;
    logic [ADDR_W-1:0]    out_pc;
    logic [4:0]           out_rs;
    logic [4:0]           out_rt;
    logic [4:0]           out_wdst;
    logic [4:0]           out_shamt;
    logic [31:0]          out_imm;
    logic [ALUCODE_W-1:0] out_alucode;
    logic                 out_memtoreg;
    logic                 out_regwrite;
    logic                 out_memwrite;
    logic                 out_memread;
    logic                 out_alusrca;
    logic                 out_alusrcb;
    logic                 out_j;
    logic                 out_jr;
    logic                 out_illegal;
    logic [1:0]           out_mem_size;
    logic                 out_mem_unsigned;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rs, out_rt, out_wdst, out_shamt,
               out_imm, out_alucode, out_memtoreg, out_regwrite, out_memwrite,
               out_memread, out_alusrca, out_alusrcb, out_j, out_jr, out_illegal,
               out_mem_size, out_mem_unsigned
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rs, out_rt, out_wdst, out_shamt,
               out_imm, out_alucode, out_memtoreg, out_regwrite, out_memwrite,
               out_memread, out_alusrca, out_alusrcb, out_j, out_jr, out_illegal,
               out_mem_size, out_mem_unsigned
    );
endinterface

// File: rtl/decode_stage_reg.sv
// MIPS instruction decode stage with ID/EX output register, one-bubble load-use interlock and flush.
// Latency 1 cycle input transfer -> out_valid; 1 instr/cycle without hazards.
// Backpressure: holds while out_ready=0; in_ready drops on flush or load-use hazard.
// Ports: clk, reset (async active-high), flush, bubble_cnt (saturating), bus (decode_stage_reg_if.slave).
// Optional feature macro DECODE_BYTE_MEM_EN adds LB/LBU/SB decode.
module decode_stage_reg #(
    parameter int ADDR_W    = 32,
    parameter int ALUCODE_W = 5,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    output logic [CNT_W-1:0]  bubble_cnt,
    decode_stage_reg_if.slave bus
);
    localparam logic [4:0] A_ADD = 5'd0,  A_AND = 5'd1,  A_XOR = 5'd2,  A_OR = 5'd3;
    localparam logic [4:0] A_NOR = 5'd4,  A_SUB = 5'd5,  A_ANDI = 5'd6, A_XORI = 5'd7;
    localparam logic [4:0] A_ORI = 5'd8,  A_JR = 5'd9,   A_BEQ = 5'd10, A_BNE = 5'd11;
    localparam logic [4:0] A_BGEZ = 5'd12, A_BGTZ = 5'd13, A_BLEZ = 5'd14, A_BLTZ = 5'd15;
    localparam logic [4:0] A_SLL = 5'd16, A_SRL = 5'd17, A_SRA = 5'd18, A_SLT = 5'd19;
    localparam logic [4:0] A_SLTU = 5'd20;

    typedef struct packed {
        logic [ADDR_W-1:0]    pc;
        logic [4:0]           rs;
        logic [4:0]           rt;
        logic [4:0]           wdst;
        logic [4:0]           shamt;
        logic [31:0]          imm;
        logic [ALUCODE_W-1:0] alucode;
        logic                 memtoreg;
        logic                 regwrite;
        logic                 memwrite;
        logic                 memread;
        logic                 alusrca;
        logic                 alusrcb;
        logic                 j;
        logic                 jr;
        logic                 illegal;
        logic [1:0]           mem_size;
        logic                 mem_unsigned;
    } bundle_t;

    bundle_t    dec;
    bundle_t    held;
    logic       held_vld;
    logic       uses_rs;
    logic       uses_rt;
    logic       hazard;
    logic [4:0] code;
    logic       legal, r_alu, shift_imm, i_alu, zext, ld, st, br, rs_br, is_j, is_jr;
    logic       beq_bne;

    wire [5:0] op    = bus.in_instr[31:26];
    wire [4:0] rs    = bus.in_instr[25:21];
    wire [4:0] rt    = bus.in_instr[20:16];
    wire [4:0] rd    = bus.in_instr[15:11];
    wire [5:0] funct = bus.in_instr[5:0];

    always_comb begin
        code      = A_ADD;
        legal     = 1'b1;
        r_alu     = 1'b0;
        shift_imm = 1'b0;
        i_alu     = 1'b0;
        zext      = 1'b0;
        ld        = 1'b0;
        st        = 1'b0;
        br        = 1'b0;
        beq_bne   = 1'b0;
        rs_br     = 1'b0;
        is_j      = 1'b0;
        is_jr     = 1'b0;
        dec              = '0;
        dec.mem_size     = 2'b10;
        dec.mem_unsigned = 1'b0;
        case (op)
            6'b000000: begin
                r_alu = 1'b1;
                case (funct)
                    6'h20, 6'h21: code = A_ADD;
                    6'h22, 6'h23: code = A_SUB;
                    6'h24:        code = A_AND;
                    6'h25:        code = A_OR;
                    6'h26:        code = A_XOR;
                    6'h27:        code = A_NOR;
                    6'h2A:        code = A_SLT;
                    6'h2B:        code = A_SLTU;
                    6'h04:        code = A_SLL;
                    6'h06:        code = A_SRL;
                    6'h07:        code = A_SRA;
                    6'h00: begin code = A_SLL; r_alu = 1'b0; shift_imm = 1'b1; end
                    6'h02: begin code = A_SRL; r_alu = 1'b0; shift_imm = 1'b1; end
                    6'h03: begin code = A_SRA; r_alu = 1'b0; shift_imm = 1'b1; end
                    6'h08: begin code = A_JR;  r_alu = 1'b0; is_jr = 1'b1; end
                    default: begin r_alu = 1'b0; legal = 1'b0; end
                endcase
            end
            // REGIMM: only BLTZ (rt=0) and BGEZ (rt=1) exist here
            6'b000001: begin
                if (rt == 5'd0)      begin br = 1'b1; code = A_BLTZ; end
                else if (rt == 5'd1) begin br = 1'b1; code = A_BGEZ; end
                else                 legal = 1'b0;
            end
            6'b000010: is_j = 1'b1;
            6'b000100: begin br = 1'b1; beq_bne = 1'b1; code = A_BEQ; end
            6'b000101: begin br = 1'b1; beq_bne = 1'b1; code = A_BNE; end
            6'b000110: begin br = 1'b1; code = A_BLEZ; end
            6'b000111: begin br = 1'b1; code = A_BGTZ; end
            6'b001000, 6'b001001: begin i_alu = 1'b1; code = A_ADD; end
            6'b001010: begin i_alu = 1'b1; code = A_SLT;  end
            6'b001011: begin i_alu = 1'b1; code = A_SLTU; end
            6'b001100: begin i_alu = 1'b1; zext = 1'b1; code = A_ANDI; end
            6'b001101: begin i_alu = 1'b1; zext = 1'b1; code = A_ORI;  end
            6'b001110: begin i_alu = 1'b1; zext = 1'b1; code = A_XORI; end
            6'b100011: ld = 1'b1;
            6'b101011: st = 1'b1;
`ifdef DECODE_BYTE_MEM_EN
            6'b100000: begin ld = 1'b1; dec.mem_size = 2'b00; end
            6'b100100: begin ld = 1'b1; dec.mem_size = 2'b00; dec.mem_unsigned = 1'b1; end
            6'b101000: begin st = 1'b1; dec.mem_size = 2'b00; end
`endif
            default: legal = 1'b0;
        endcase
        rs_br = br;

        dec.pc       = bus.in_pc;
        dec.rs       = rs;
        dec.rt       = rt;
        dec.wdst     = (r_alu | shift_imm) ? rd : rt;
        dec.shamt    = bus.in_instr[10:6];
        dec.imm      = zext ? {16'h0000, bus.in_instr[15:0]}
                            : {{16{bus.in_instr[15]}}, bus.in_instr[15:0]};
        dec.alucode  = ALUCODE_W'(code);
        dec.memtoreg = ld;
        dec.memread  = ld;
        dec.memwrite = st;
        dec.regwrite = ld | r_alu | shift_imm | i_alu;
        dec.alusrca  = shift_imm;
        dec.alusrcb  = i_alu | ld | st;
        dec.j        = is_j;
        dec.jr       = is_jr;
        dec.illegal  = ~legal;

        uses_rs = r_alu | i_alu | ld | st | rs_br | is_jr;
        uses_rt = r_alu | shift_imm | st | beq_bne;
    end

    // Dependent instruction waits one cycle behind a load whose result it reads.
    assign hazard = held_vld & held.memread & (held.wdst != 5'd0) & bus.in_valid &
                    ((uses_rs & (rs == held.wdst)) | (uses_rt & (rt == held.wdst)));

    assign bus.in_ready = ~flush & ~hazard & (~held_vld | bus.out_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held_vld      <= 1'b0;
            held          <= '0;
            held.mem_size <= 2'b10;
            bubble_cnt    <= '0;
        end else if (flush) begin
            held_vld <= 1'b0;
        end else if (hazard) begin
            if (bus.out_ready) begin
                held_vld <= 1'b0;
                if (bubble_cnt != '1)
                    bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end else if (bus.in_valid && bus.in_ready) begin
            held_vld <= 1'b1;
            held     <= dec;
        end else if (bus.out_ready) begin
            held_vld <= 1'b0;
        end
    end

    assign bus.out_valid        = held_vld;
    assign bus.out_pc           = held.pc;
    assign bus.out_rs           = held.rs;
    assign bus.out_rt           = held.rt;
    assign bus.out_wdst         = held.wdst;
    assign bus.out_shamt        = held.shamt;
    assign bus.out_imm          = held.imm;
    assign bus.out_alucode      = held.alucode;
    assign bus.out_memtoreg     = held.memtoreg;
    assign bus.out_regwrite     = held.regwrite;
    assign bus.out_memwrite     = held.memwrite;
    assign bus.out_memread      = held.memread;
    assign bus.out_alusrca      = held.alusrca;
    assign bus.out_alusrcb      = held.alusrcb;
    assign bus.out_j            = held.j;
    assign bus.out_jr           = held.jr;
    assign bus.out_illegal      = held.illegal;
    assign bus.out_mem_size     = held.mem_size;
    assign bus.out_mem_unsigned = held.mem_unsigned;
endmodule
